cpu_data_mem: RTL and testbench
===============================

# cpu_data_mem

Data-side memory responder for the single-cycle `cpu`. It consumes the core's `memwrite`, `aluout` and `writedata` outputs and returns `readdata` in the same cycle. It holds a word-addressed data RAM plus a small MMIO window with an LED register, a free-running cycle counter, and a transmit FIFO that drains to an external consumer over valid/ready. It sits beside `cpu` at the top level, opposite the instruction source.

## Interface
- `n`, 32: data/address width
- `DMEM_WORDS`, 64: RAM depth in words (power of two)
- `FIFO_DEPTH`, 8: TX FIFO depth (power of two, ≥2)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `memwrite`  in  1  store strobe from core
- `aluout`  in  n  byte address from core
- `writedata`  in  n  store data from core
- `readdata`  out  n  load data to core, combinational from `aluout`
- `led`  out  8  LED register
- `tx_data`  out  n  FIFO head word
- `tx_valid`  out  1  FIFO non-empty
- `tx_ready`  in  1  consumer accepts head when `tx_valid & tx_ready`

## Operation
- Decode: `aluout[31]==0` is RAM, word index `aluout[$clog2(DMEM_WORDS)+1:2]` (upper bits ignored, aliasing). `aluout[1:0]` is ignored; there are no byte lanes.
- `aluout[31]==1` is MMIO, decoded on `aluout[7:0]`:
  - 0x00 LED: read `{24'b0, led}`; write loads `writedata[7:0]`.
  - 0x04 CYCLES: read counter; any write clears it.
  - 0x08 TX: write pushes `writedata`; read returns `{…0, count}`.
  - 0x0C STATUS: read `{29'b0, ovf, full, empty}`; a write with `writedata[2]=1` clears `ovf`.
  - Other offsets read 0 and ignore writes.
- RAM read is combinational. RAM write happens at the clock edge when `memwrite=1`.
- Counter increments every cycle and wraps 0xFFFFFFFF→0. On a clear write the next value is 0; clear beats increment.
- FIFO push is accepted when not full, or when full and a pop happens in the same cycle. Otherwise the word is dropped and sticky `ovf` is set.
- FIFO pop happens when `tx_valid & tx_ready`. Pop and push in the same cycle at nonzero count leave count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- An `ovf` clear write coinciding with a new overflow leaves `ovf=1`.
- `readdata` is X-free for every address.

## Timing
- Reset values:
  - `led=0`, counter=0, FIFO empty (`tx_valid=0`, count=0), `ovf=0`, all RAM words 0.
  - `tx_data` equals the stale head when empty; it is only meaningful with `tx_valid`.
  - `readdata` follows decode during reset.
- Store latency: a write at edge k is visible on `readdata` after edge k for the same address. A load in the same cycle as the store returns the old value.
- Push→`tx_valid`: a push at edge k gives `tx_valid=1` after edge k. `tx_data` is the registered head with no combinational path from `writedata`.
- The counter reads N at N edges after reset deasserts.
- Reset asserted mid-drain empties the FIFO at that edge. A pending handshake is lost; consumers must not count it.

## Structure
- `cpu_mem_pkg` holds:
  - address constants `MMIO_BASE=32'h8000_0000`, offsets `LED_OFS`, `CYC_OFS`, `TX_OFS`, `STAT_OFS`
  - status bit indices `ST_EMPTY=0`, `ST_FULL=1`, `ST_OVF=2`
- One sub-module, `mem_tx_fifo`, is a synchronous FIFO with push/pop, full/empty/count, and parameter `DEPTH`. `cpu_data_mem` owns the decode, RAM, LED, counter and `ovf` logic.

## Test plan
- Reset then store/load:
  - Store 0xDEADBEEF to 0x0000_0010, then read 0x10 → `readdata=0xDEADBEEF`.
  - Read 0x0000_0110 → `readdata=0xDEADBEEF` (alias).
  - A same-cycle read before the edge returns 0.
- LED and unmapped: write 0x1A5 to 0x8000_0000 → `led=0xA5`, and a read returns 0xA5. Reading 0x8000_0020 returns 0.
- Counter:
  - 5 idle cycles after reset → read 0x8000_0004 = 5.
  - A write there returns 0 next cycle, then 1.
  - Force the value 0xFFFFFFFF → next read 0.
- FIFO drain:
  - Push 1,2,3 with `tx_ready=0` → count=3, `tx_valid=1`, `tx_data=1`.
  - Raise `tx_ready` → outputs 1,2,3 on consecutive cycles, then `tx_valid=0` and STATUS=0x1.
- Overflow:
  - Push 9 words with `tx_ready=0` → STATUS=0x6 (full and ovf), and the 9th word is never emitted.
  - Push while full with `tx_ready=1` → accepted, `ovf` not set.
  - Write 0x4 to STATUS → `ovf` clears.
- Reset mid-operation: with 4 words queued and a RAM word written, assert `reset` for 1 cycle → `tx_valid=0`, `led=0`, RAM reads 0, counter restarts at 0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared address map and status bit layout for cpu_data_mem
//
// Purpose: MMIO base/offsets, STATUS bit indices and the address decode
// helper used by the data-side memory responder.
// Ports: none (package).

package cpu_mem_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [7:0] LED_OFS  = 8'h00;
  localparam logic [7:0] CYC_OFS  = 8'h04;
  localparam logic [7:0] TX_OFS   = 8'h08;
  localparam logic [7:0] STAT_OFS = 8'h0C;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LED,
    SEL_CYC,
    SEL_TX,
    SEL_STAT,
    SEL_NONE
  } sel_e;

  // Bit 31 splits RAM from MMIO; only the low byte selects an MMIO register.
  function automatic sel_e decode(input logic [31:0] addr);
    sel_e sel;
    sel = SEL_NONE;
    if (addr[31] == 1'b0) begin
      sel = SEL_RAM;
    end else begin
      case (addr[7:0])
        LED_OFS:  sel = SEL_LED;
        CYC_OFS:  sel = SEL_CYC;
        TX_OFS:   sel = SEL_TX;
        STAT_OFS: sel = SEL_STAT;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_tx_fifo.sv
// rtl/mem_tx_fifo.sv - synchronous transmit FIFO with push/pop and occupancy
//
// Purpose: holds MMIO TX words until the external consumer takes them.
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_push, i_wdata   push strobe and word
//   i_pop             pop request (ignored when empty)
//   o_rdata           registered head word (stale when empty)
//   o_full, o_empty   occupancy flags
//   o_push_ok         push is accepted this cycle
//   o_count           current occupancy

module mem_tx_fifo
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_push_ok,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [PW:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);

  assign o_push_ok = w_push;
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_data_mem.sv
// rtl/cpu_data_mem.sv - data RAM plus LED/cycle counter/TX FIFO MMIO for the cpu
//
// Purpose: data-side memory responder; combinational loads, stores at the edge.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   memwrite            store strobe
//   aluout              byte address (bit 31 selects MMIO)
//   writedata           store data
//   readdata            combinational load data
//   led                 LED register
//   tx_data, tx_valid   FIFO head and non-empty flag
//   tx_ready            consumer takes the head on tx_valid & tx_ready

module cpu_data_mem
  import cpu_mem_pkg::*;
#(
  parameter int n          = 32,
  parameter int DMEM_WORDS = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] aluout,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic [7:0]   led,
  output logic [n-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [n-1:0] r_ram [DMEM_WORDS];
  logic [7:0]   r_led;
  logic [n-1:0] r_cycles;
  logic         r_ovf;

  sel_e         w_sel;
  logic [AW-1:0] w_idx;
  logic         w_wr_ram;
  logic         w_wr_led;
  logic         w_wr_cyc;
  logic         w_tx_push;
  logic         w_wr_stat;
  logic         w_tx_pop;
  logic         w_push_ok;
  logic         w_full;
  logic         w_empty;
  logic [CW-1:0] w_count;
  logic         w_unused;

  assign w_sel = decode(aluout);
  // Upper address bits alias onto the RAM; byte offset bits are ignored.
  assign w_idx = aluout[AW+1:2];
  assign w_unused = ^{aluout[30:8], aluout[1:0]};

  assign w_wr_ram  = memwrite & (w_sel == SEL_RAM);
  assign w_wr_led  = memwrite & (w_sel == SEL_LED);
  assign w_wr_cyc  = memwrite & (w_sel == SEL_CYC);
  assign w_tx_push = memwrite & (w_sel == SEL_TX);
  assign w_wr_stat = memwrite & (w_sel == SEL_STAT);

  assign w_tx_pop = tx_valid & tx_ready;
  assign tx_valid = ~w_empty;
  assign led      = r_led;

  mem_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (n)
  ) u_tx_fifo (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_push    (w_tx_push),
    .i_wdata   (writedata),
    .i_pop     (w_tx_pop),
    .o_rdata   (tx_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        r_ram[i] <= '0;
      end
      r_led    <= '0;
      r_cycles <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_ram) begin
        r_ram[w_idx] <= writedata;
      end
      if (w_wr_led) begin
        r_led <= writedata[7:0];
      end
      // Clear wins over the free-running increment.
      r_cycles <= w_wr_cyc ? '0 : r_cycles + 1'b1;
      // A fresh overflow wins over a clear in the same cycle.
      if (w_tx_push & ~w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_wr_stat & writedata[ST_OVF]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (w_sel)
      SEL_RAM:  readdata = r_ram[w_idx];
      SEL_LED:  readdata = {{(n-8){1'b0}}, r_led};
      SEL_CYC:  readdata = r_cycles;
      SEL_TX:   readdata = {{(n-CW){1'b0}}, w_count};
      SEL_STAT: begin
        readdata[ST_EMPTY] = w_empty;
        readdata[ST_FULL]  = w_full;
        readdata[ST_OVF]   = r_ovf;
      end
      default:  readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu_data_mem.sv
// tb/tb_cpu_data_mem.sv - directed self-checking bench for cpu_data_mem

module tb_cpu_data_mem;

  localparam logic [31:0] A_LED  = 32'h8000_0000;
  localparam logic [31:0] A_CYC  = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_STAT = 32'h8000_000C;
  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];

  cpu_data_mem #(
    .n          (32),
    .DMEM_WORDS (64),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .led       (led),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    aluout = addr;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    memwrite  = 1'b1;
    aluout    = addr;
    writedata = data;
    tick();
    memwrite  = 1'b0;
  endtask

  // Model: a pop happens first if the consumer is ready, then the word
  // lands only if there is room left.
  task automatic push_tx(input logic [31:0] data);
    if (tx_ready && sb_q.size() > 0) begin
      chk("tx_head_on_push", tx_data, sb_q[0]);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() < DEPTH) begin
      sb_q.push_back(data);
    end
    store(A_TX, data);
  endtask

  task automatic drain(input int max_cycles);
    tx_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      #1;
      if (tx_valid) begin
        if (sb_q.size() == 0) begin
          chk("tx_unexpected_word", tx_data, 32'hxxxx_xxxx);
        end else begin
          chk("tx_data_drain", tx_data, sb_q[0]);
          void'(sb_q.pop_front());
        end
      end
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    aluout    = '0;
    writedata = '0;
    tx_ready  = 1'b0;
    tick();
    tick();

    chk("rst_led", {24'b0, led}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    rd("rst_status", A_STAT, 32'h1);
    rd("rst_ram", 32'h10, 32'd0);
    rd("rst_cycles", A_CYC, 32'd0);

    reset = 1'b0;
    repeat (5) tick();
    rd("cycles_after_5", A_CYC, 32'd5);

    store(A_CYC, 32'h1234);
    rd("cycles_cleared", A_CYC, 32'd0);
    tick();
    rd("cycles_after_clear", A_CYC, 32'd1);

    memwrite  = 1'b1;
    aluout    = 32'h10;
    writedata = 32'hDEAD_BEEF;
    #1;
    chk("ram_same_cycle_old", readdata, 32'd0);
    tick();
    memwrite = 1'b0;
    rd("ram_load", 32'h10, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h110, 32'hDEAD_BEEF);

    store(A_LED, 32'h1A5);
    chk("led_port", {24'b0, led}, 32'hA5);
    rd("led_read", A_LED, 32'hA5);
    rd("unmapped_read", 32'h8000_0020, 32'd0);

    aluout = A_CYC;
    force dut.r_cycles = 32'hFFFF_FFFF;
    tick();
    rd("cycles_forced", A_CYC, 32'hFFFF_FFFF);
    release dut.r_cycles;
    tick();
    rd("cycles_wrap", A_CYC, 32'd0);

    push_tx(32'd1);
    push_tx(32'd2);
    push_tx(32'd3);
    rd("tx_count_3", A_TX, 32'd3);
    chk("tx_valid_3", {31'b0, tx_valid}, 32'd1);
    chk("tx_head_3", tx_data, 32'd1);
    drain(6);
    chk("tx_valid_drained", {31'b0, tx_valid}, 32'd0);
    rd("status_drained", A_STAT, 32'h1);

    for (int i = 0; i < 9; i++) begin
      push_tx(32'h100 + 32'(i));
    end
    rd("status_ovf", A_STAT, 32'h6);
    rd("tx_count_full", A_TX, 32'd8);
    store(A_STAT, 32'h3);
    rd("status_no_clear", A_STAT, 32'h6);
    store(A_STAT, 32'h4);
    rd("status_ovf_cleared", A_STAT, 32'h2);
    tx_ready = 1'b1;
    push_tx(32'h200);
    tx_ready = 1'b0;
    rd("status_full_push_pop", A_STAT, 32'h2);
    drain(12);
    chk("tx_valid_after_ovf", {31'b0, tx_valid}, 32'd0);
    rd("status_after_ovf", A_STAT, 32'h1);

    for (int i = 0; i < 4; i++) begin
      push_tx(32'h300 + 32'(i));
    end
    store(32'h20, 32'h55);
    store(A_LED, 32'h3C);
    rd("ram_before_reset", 32'h20, 32'h55);
    chk("tx_valid_before_reset", {31'b0, tx_valid}, 32'd1);
    reset = 1'b1;
    tick();
    sb_q.delete();
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_led", {24'b0, led}, 32'd0);
    rd("mid_rst_ram20", 32'h20, 32'd0);
    rd("mid_rst_ram10", 32'h10, 32'd0);
    rd("mid_rst_cycles", A_CYC, 32'd0);
    reset = 1'b0;
    tick();
    rd("cycles_restart", A_CYC, 32'd1);
    rd("status_after_reset", A_STAT, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
